fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the program counter and instruction fetch for the single-issue core.
//  Issues one instruction-memory request per PC value and holds the returned word until decode accepts it.
//  Drives the PC register's load/PCsrc controls only when an instruction retires.
//  Handles boot delay, halt, flush and a fetch timeout.
// PARAMETERS
//  AW          32   PC / fetch address width
//  DW          32   instruction width
//  BOOT_CYC    4    cycles held in BOOT after reset release before first fetch (>=1)
//  TIMEOUT     255  max cycles in WAIT without imem_rvalid before ERR (>=1)
// PORTS
//  clk          in   1   rising-edge clock
//  arst         in   1   asynchronous reset, active-high
//  pc           in   AW  current PC from program counter
//  branch_taken in   1   execute resolves taken branch/jump for instruction being accepted
//  flush        in   1   discard in-flight/held instruction, refetch from pc
//  halt_req     in   1   stop fetching at next instruction boundary
//  imem_req     out  1   fetch request, held until imem_gnt
//  imem_addr    out  AW  fetch address (= pc while imem_req)
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   response valid (1-cycle pulse)
//  imem_rdata   in   DW  response instruction word
//  instr_valid  out  1   instr holds valid instruction for decode
//  instr        out  DW  held instruction word
//  instr_ready  in   1   decode/execute consumes instr this cycle
//  pc_load      out  1   1-cycle pulse: PC register loads next PC
//  pc_src       out  1   PCsrc for that load: 1 = PC+immext, 0 = PC+4
//  halted       out  1   sequencer in HALT
//  fetch_err    out  1   sticky, set on timeout, cleared only by arst
// BEHAVIOUR
//  Reset (arst=1, async): state=BOOT, boot/timeout counters=0, drop=0; all outputs 0, instr=0.
//  States: BOOT, REQ, WAIT, HOLD, HALT, ERR.
//  BOOT: count BOOT_CYC cycles -> REQ (-> HALT if halt_req at exit).
//  REQ: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT, timeout counter cleared.
//  WAIT: on imem_rvalid & !drop: capture imem_rdata into instr -> HOLD (instr_valid=1 next cycle).
//        on imem_rvalid & drop: discard, clear drop -> REQ.
//        counter increments each cycle without rvalid; reaching TIMEOUT -> ERR, fetch_err=1.
//  HOLD: instr_valid=1, instr stable. On instr_ready: pc_load=1, pc_src=branch_taken (same cycle,
//        combinational), then -> REQ, or -> HALT if halt_req sampled that cycle.
//  HALT: halted=1, no requests, no pc_load; halt_req=0 -> REQ.
//  ERR: terminal; imem_req=0, instr_valid=0, pc_load=0 until arst.
//  Flush (highest priority below arst, ignored in BOOT/ERR):
//   REQ: no effect (request re-issued at new pc). WAIT: set drop, stay WAIT.
//   HOLD: instr_valid drops next cycle, no pc_load even if instr_ready same cycle -> REQ.
//   HALT: no effect.
//  Latency: gnt in cycle N, rvalid N+k (k>=1) -> instr_valid from N+k+1; accept cycle A ->
//   pc_load in A, imem_req reasserted in A+1 with updated pc.
//  At most one request outstanding; imem_req never asserted in WAIT/HOLD.
//  rvalid outside WAIT is ignored. pc_load never asserted outside HOLD.
//  Simultaneous gnt+rvalid in REQ: rvalid ignored (response belongs to no request).
//  arst mid-WAIT: outstanding response after reset is ignored (state BOOT).
// TESTING
//  1 arst pulse, BOOT_CYC=4 -> imem_req rises 4 cycles after release, imem_addr=pc=0x0.
//  2 gnt immediate, rvalid 2 cycles later data 0x00500093, instr_ready=1, branch_taken=0
//    -> instr_valid 1 cycle, pc_load=1 pc_src=0; next req addr=0x4.
//  3 accept with branch_taken=1, pc becomes 0x40 -> pc_src=1 on pc_load; next req addr=0x40.
//  4 flush during WAIT, then rvalid 0xDEADBEEF -> word dropped, instr_valid stays 0, new req issued.
//  5 instr_ready=0 for 5 cycles in HOLD -> instr stable, no pc_load; halt_req at accept -> halted=1.
//  6 no rvalid for TIMEOUT=8 cycles -> fetch_err=1, imem_req=0 permanently until arst.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/response and decode handshake bundle
interface fetch_sequencer_if #(parameter int AW = 32, parameter int DW = 32);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic          instr_ready;
    modport master (
        output imem_req, imem_addr, instr_valid, instr,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing and single-outstanding instruction fetch with boot, halt, flush and timeout
module fetch_sequencer #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int BOOT_CYC = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [AW-1:0]     pc,
    input  logic              branch_taken,
    input  logic              flush,
    input  logic              halt_req,
    fetch_sequencer_if.master bus,
    output logic              pc_load,
    output logic              pc_src,
    output logic              halted,
    output logic              fetch_err
);
    localparam int BW = $clog2(BOOT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, HALT, ERR} state_t;
    state_t        state, state_nx;
    logic [BW-1:0] boot_cnt;
    logic [TW-1:0] to_cnt;
    logic          drop;
    logic          take;
    logic [DW-1:0] instr_q;
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        pc_load  = 1'b0;
        case (state)
            BOOT: if (boot_cnt == BW'(BOOT_CYC - 1)) state_nx = halt_req ? HALT : REQ;
            REQ:  if (bus.imem_gnt) state_nx = WAIT;
            WAIT: begin
                // a flush arriving with the response discards it just like a pending drop
                if (bus.imem_rvalid) begin
                    take     = !(drop || flush);
                    state_nx = take ? HOLD : REQ;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    state_nx = ERR;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nx = REQ;
                end else if (bus.instr_ready) begin
                    pc_load  = 1'b1;
                    state_nx = halt_req ? HALT : REQ;
                end
            end
            HALT: if (!halt_req) state_nx = REQ;
            default: ;
        endcase
    end
    assign bus.imem_req    = state == REQ;
    assign bus.imem_addr   = bus.imem_req ? pc : '0;
    assign bus.instr_valid = state == HOLD;
    assign bus.instr       = instr_q;
    assign pc_src          = pc_load & branch_taken;
    assign halted          = state == HALT;
    assign fetch_err       = state == ERR;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= BOOT;
            boot_cnt <= '0;
            to_cnt   <= '0;
            drop     <= 1'b0;
            instr_q  <= '0;
        end else begin
            state    <= state_nx;
            boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
            to_cnt   <= (state == WAIT && !bus.imem_rvalid) ? to_cnt + 1'b1 : '0;
            drop     <= (state == WAIT) && !bus.imem_rvalid && (drop || flush);
            if (take) instr_q <= bus.imem_rdata;
        end
    end
endmodule
